// File: rtl/tlb_manager_if.sv
// tlb_manager_if: request, CP0-operand and result signals of the TLB management unit.
//
// Handshake: a request is taken on the rising clk edge where op_valid && op_ready.
// op_ready is high only while the unit is idle and out of reset. op_valid while
// busy is ignored, and nothing is queued. Every accepted op produces exactly one
// single-cycle done pulse, together with one of the tlb_we, rd_we or index_we strobes.
//
// modport master : CP0 / pipeline side (drives requests and operands)
// modport slave  : tlb_manager (drives status, random, write port and results)
interface tlb_manager_if;
  logic        op_valid;
  logic [1:0]  op;
  logic        op_ready;
  logic        busy;
  logic        done;
  logic [31:0] cp0_entryhi;
  logic [31:0] cp0_entrylo0;
  logic [31:0] cp0_entrylo1;
  logic [3:0]  cp0_index;
  logic [3:0]  cp0_wired;
  logic        cp0_wired_we;
  logic [3:0]  random;
  logic        tlb_we;
  logic [3:0]  tlb_index;
  logic [62:0] tlb_data;
  logic        index_we;
  logic [31:0] index_data;
  logic        rd_we;
  logic [31:0] rd_entryhi;
  logic [31:0] rd_entrylo0;
  logic [31:0] rd_entrylo1;

  modport master (
    output op_valid, op, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
           cp0_index, cp0_wired, cp0_wired_we,
    input  op_ready, busy, done, random, tlb_we, tlb_index, tlb_data,
           index_we, index_data, rd_we, rd_entryhi, rd_entrylo0, rd_entrylo1
  );

  modport slave (
    input  op_valid, op, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
           cp0_index, cp0_wired, cp0_wired_we,
    output op_ready, busy, done, random, tlb_we, tlb_index, tlb_data,
           index_we, index_data, rd_we, rd_entryhi, rd_entrylo0, rd_entrylo1
  );
endinterface

// File: rtl/tlb_manager.sv
// tlb_manager: CP0-side TLB management. Executes TLBP/TLBR/TLBWI/TLBWR, keeps
// the authoritative 16 x 63-bit shadow of the TLB, drives the lookup block's
// write port and maintains the Random register.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : tlb_manager_if.slave (request handshake, CP0 operands, results)
//   dbg_state  : current FSM state (0 IDLE, 1 PROBE, 2 DONE)
//
// Build option: TLB_FAST_PROBE_EN -- TLBP searches all entries in parallel at
// the accept edge and completes one cycle later. Undefined: TLBP scans one
// entry per cycle in the PROBE state.
module tlb_manager (
  input  logic             clk,
  input  logic             rst,
  tlb_manager_if.slave     bus,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, PROBE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  idx_q, idx_d;      // target entry, scan pointer, or probe result
  logic        miss_q, miss_d;
  logic [62:0] data_q, data_d;    // packed operands; [62:44] doubles as probe key
  logic [3:0]  random_q, random_d;
  logic [62:0] shadow_q [16];
  logic [62:0] shadow_d [16];

  logic        accept;
  logic [62:0] packed_in;
  logic [62:0] rd_entry;
  logic        unused_operand_bits;

  assign accept    = bus.op_valid && bus.op_ready;
  assign packed_in = {bus.cp0_entryhi[31:13],
                      bus.cp0_entrylo1[25:6], bus.cp0_entrylo1[2], bus.cp0_entrylo1[1],
                      bus.cp0_entrylo0[25:6], bus.cp0_entrylo0[2], bus.cp0_entrylo0[1]};

  assign unused_operand_bits = ^{bus.cp0_entryhi[12:0],
                                 bus.cp0_entrylo0[31:26], bus.cp0_entrylo0[5:3], bus.cp0_entrylo0[0],
                                 bus.cp0_entrylo1[31:26], bus.cp0_entrylo1[5:3], bus.cp0_entrylo1[0]};

`ifdef TLB_FAST_PROBE_EN
  logic       fast_hit;
  logic [3:0] fast_idx;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    fast_hit = 1'b0;
    fast_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (shadow_q[i][62:44] == packed_in[62:44]) begin
        fast_hit = 1'b1;
        fast_idx = 4'(i);
      end
    end
  end
`endif

  // Random counts down to Wired and wraps to 15; a Wired write restarts it.
  // Using <= rather than == keeps it in range if Wired ever exceeds Random.
  always_comb begin
    random_d = random_q - 4'd1;
    if (bus.cp0_wired_we || (random_q <= bus.cp0_wired)) random_d = 4'hF;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    miss_d   = miss_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.op;
          data_d  = packed_in;
          idx_d   = (bus.op == OP_TLBWR) ? random_q : bus.cp0_index;
          miss_d  = 1'b0;
          state_d = DONE;
          if (bus.op == OP_TLBP) begin
`ifdef TLB_FAST_PROBE_EN
            idx_d  = fast_idx;
            miss_d = ~fast_hit;
`else
            idx_d   = 4'd0;
            state_d = PROBE;
`endif
          end
        end
      end
      PROBE: begin
        if (shadow_q[idx_q][62:44] == data_q[62:44]) begin
          state_d = DONE;
        end else if (idx_q == 4'd15) begin
          miss_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (op_q[1]) shadow_d[idx_q] = data_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      idx_q    <= 4'd0;
      miss_q   <= 1'b0;
      data_q   <= '0;
      random_q <= 4'hF;
      for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      miss_q   <= miss_d;
      data_q   <= data_d;
      random_q <= random_d;
      for (int i = 0; i < 16; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign rd_entry = shadow_q[idx_q];

  always_comb begin
    bus.op_ready    = (state_q == IDLE) && !rst;
    bus.busy        = (state_q != IDLE);
    bus.done        = (state_q == DONE);
    bus.random      = random_q;
    bus.tlb_we      = bus.done && op_q[1];
    bus.tlb_index   = bus.tlb_we ? idx_q : 4'd0;
    bus.tlb_data    = bus.tlb_we ? data_q : 63'd0;
    bus.index_we    = bus.done && (op_q == OP_TLBP);
    bus.index_data  = 32'd0;
    if (bus.index_we) bus.index_data = miss_q ? 32'h8000_0000 : {28'd0, idx_q};
    bus.rd_we       = bus.done && (op_q == OP_TLBR);
    bus.rd_entryhi  = 32'd0;
    bus.rd_entrylo0 = 32'd0;
    bus.rd_entrylo1 = 32'd0;
    if (bus.rd_we) begin
      bus.rd_entryhi  = {rd_entry[62:44], 13'd0};
      bus.rd_entrylo1 = {6'd0, rd_entry[43:24], 3'd0, rd_entry[23], rd_entry[22], 1'b0};
      bus.rd_entrylo0 = {6'd0, rd_entry[21:2], 3'd0, rd_entry[1], rd_entry[0], 1'b0};
    end
  end

  assign dbg_state = state_q;
endmodule

// File: tb/tb_tlb_manager.sv
module tb_tlb_manager;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  tlb_manager_if bus();

  tlb_manager dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int tests = 0;
  int fails = 0;
  int rand_cyc = 0;       // clock edges since reset or last Wired write
  int done_seen = 0;
  int done_exp = 0;
  logic [31:0] m_hi  [16];
  logic [31:0] m_lo0 [16];
  logic [31:0] m_lo1 [16];
  logic [66:0] exp_q [$]; // expected {tlb_index, tlb_data} per write strobe
  logic [18:0] vpn_pool [4] = '{19'h00010, 19'h055E6, 19'h12345, 19'h7ABCD};

  always @(posedge clk) begin
    if (rst || bus.cp0_wired_we) rand_cyc <= 0;
    else                         rand_cyc <= rand_cyc + 1;
  end

  // Random walks 15 down to Wired, period 16-Wired, restarting at 15.
  function automatic int exp_rand();
    return 15 - (rand_cyc % (16 - int'(bus.cp0_wired)));
  endfunction

  function automatic logic [62:0] pack(input logic [31:0] hi, input logic [31:0] lo0,
                                       input logic [31:0] lo1);
    return {hi[31:13], lo1[25:6], lo1[2], lo1[1], lo0[25:6], lo0[2], lo0[1]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard on the write port ----------------
  always @(negedge clk) begin
    logic [66:0] e;
    if (bus.done === 1'b1) done_seen++;
    if (bus.tlb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("tlb_we_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_port_index", 64'(bus.tlb_index), 64'(e[66:63]));
        check("wr_port_data", 64'(bus.tlb_data), 64'(e[62:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    bus.op           = 2'($urandom_range(0, 3));
    bus.cp0_index    = 4'($urandom_range(0, 15));
    bus.cp0_entryhi  = $urandom();
    bus.cp0_entrylo0 = $urandom();
    bus.cp0_entrylo1 = $urandom();
  endtask

  task automatic pulse_wired(input logic [3:0] w);
    bus.cp0_wired    = w;
    bus.cp0_wired_we = 1'b1;
    @(negedge clk);
    bus.cp0_wired_we = 1'b0;
    check("random_after_wired_we", 64'(bus.random), 64'd15);
  endtask

  // Called at a negedge with the unit idle. Holds op_valid high until done while
  // scrambling the operands, so capture and ignore-while-busy are exercised.
  task automatic do_op(input logic [1:0] op, input logic [3:0] index, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1);
    int          lat;
    int          exp_lat;
    logic [3:0]  w_idx;
    logic        hit;
    logic [3:0]  hit_idx;
    logic [31:0] exp_idx_data;
    check("op_ready_idle", 64'(bus.op_ready), 64'd1);
    bus.op_valid = 1'b1; bus.op = op; bus.cp0_index = index;
    bus.cp0_entryhi = hi; bus.cp0_entrylo0 = lo0; bus.cp0_entrylo1 = lo1;
    w_idx = (op == 2'b11) ? 4'(exp_rand()) : index;
    hit = 1'b0; hit_idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (m_hi[i][31:13] == hi[31:13]) begin hit = 1'b1; hit_idx = 4'(i); end
    exp_idx_data = hit ? {28'd0, hit_idx} : 32'h8000_0000;
    exp_lat = 1;
`ifndef TLB_FAST_PROBE_EN
    if (op == 2'b00) exp_lat = hit ? 2 + int'(hit_idx) : 17;
`endif
    if (op[1]) exp_q.push_back({w_idx, pack(hi, lo0, lo1)});
    @(negedge clk);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      check("busy_in_flight", 64'(bus.busy), 64'd1);
      scramble();
      @(negedge clk);
      lat++;
    end
    check("done_latency", 64'(lat), 64'(exp_lat));
    check("tlb_we_strobe", 64'(bus.tlb_we), 64'(op[1]));
    check("rd_we_strobe", 64'(bus.rd_we), 64'(op == 2'b01));
    check("index_we_strobe", 64'(bus.index_we), 64'(op == 2'b00));
    case (op)
      2'b00: check("probe_index_data", 64'(bus.index_data), 64'(exp_idx_data));
      2'b01: begin
        check("rd_entryhi", 64'(bus.rd_entryhi), 64'(m_hi[index]));
        check("rd_entrylo0", 64'(bus.rd_entrylo0), 64'(m_lo0[index]));
        check("rd_entrylo1", 64'(bus.rd_entrylo1), 64'(m_lo1[index]));
      end
      default: begin
        check("tlb_index", 64'(bus.tlb_index), 64'(w_idx));
        m_hi[w_idx]  = hi  & 32'hFFFF_E000;
        m_lo0[w_idx] = lo0 & 32'h03FF_FFC6;
        m_lo1[w_idx] = lo1 & 32'h03FF_FFC6;
      end
    endcase
    done_exp++;
    scramble();
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("done_single_cycle", 64'(bus.done), 64'd0);
    check("idle_after_done", 64'(bus.busy), 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op = 2'b00; bus.cp0_index = 4'd0;
    bus.cp0_entryhi = '0; bus.cp0_entrylo0 = '0; bus.cp0_entrylo1 = '0;
    bus.cp0_wired = 4'd0; bus.cp0_wired_we = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);

    check("rst_op_ready", 64'(bus.op_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_random", 64'(bus.random), 64'd15);
    check("rst_tlb_we", 64'(bus.tlb_we), 64'd0);
    check("rst_tlb_data", 64'(bus.tlb_data), 64'd0);
    check("rst_index_we", 64'(bus.index_we), 64'd0);
    check("rst_index_data", 64'(bus.index_data), 64'd0);
    check("rst_rd_we", 64'(bus.rd_we), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("random_wired0", 64'(bus.random), 64'(exp_rand()));
    end
    pulse_wired(4'd12);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("random_wired12", 64'(bus.random), 64'(exp_rand()));
    end
    pulse_wired(4'd15);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("random_wired15", 64'(bus.random), 64'(exp_rand()));
    end
    pulse_wired(4'd0);

    // write / read-back of entry 5
    do_op(2'b10, 4'd5, 32'h1234_6000, 32'h0000_0046, 32'h0000_0086);
    do_op(2'b01, 4'd5, 32'h0, 32'h0, 32'h0);

    // duplicate VPN2 in entries 3 and 9: lowest index wins
    do_op(2'b10, 4'd3, 32'h0ABC_D000, $urandom(), $urandom());
    do_op(2'b10, 4'd9, 32'h0ABC_DFFF, $urandom(), $urandom());
    do_op(2'b00, 4'd0, 32'h0ABC_D123, 32'h0, 32'h0);
    do_op(2'b00, 4'd0, 32'hFFFF_E000, 32'h0, 32'h0);

    // TLBWR accepted while Random is 7
    for (int n = 0; n < 20 && exp_rand() != 7; n++) @(negedge clk);
    check("random_is_7", 64'(bus.random), 64'd7);
    do_op(2'b11, 4'd0, $urandom(), $urandom(), $urandom());
    pulse_wired(4'd0);

    // consecutive writes to one index: second wins
    do_op(2'b10, 4'd6, $urandom(), $urandom(), $urandom());
    do_op(2'b10, 4'd6, $urandom(), $urandom(), $urandom());
    do_op(2'b01, 4'd6, 32'h0, 32'h0, 32'h0);

    // random traffic with Wired = 4
    pulse_wired(4'd4);
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  rop;
      logic [31:0] rhi;
      rop = 2'($urandom_range(0, 3));
      rhi = {vpn_pool[$urandom_range(0, 3)], 13'($urandom())};
      do_op(rop, 4'($urandom_range(0, 15)), rhi, $urandom(), $urandom());
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // reset in the middle of a missing probe (cycle k+4)
    bus.op_valid = 1'b1; bus.op = 2'b00; bus.cp0_entryhi = 32'hFFFF_E000;
    @(negedge clk);
    bus.op_valid = 1'b0;
`ifdef TLB_FAST_PROBE_EN
    done_exp++;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_index_we", 64'(bus.index_we), 64'd0);
    check("midrst_random", 64'(bus.random), 64'd15);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 4; n++) do_op(2'b01, 4'($urandom_range(0, 15)), 32'h0, 32'h0, 32'h0);
    do_op(2'b00, 4'd0, 32'h0000_1FFF, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    check("done_pulse_count", 64'(done_seen), 64'(done_exp));
    check("write_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
